// File: rtl/led_fade_driver.sv
// Per-LED PWM driver with a linear fade-out after each pattern bit drops,
// producing a trailing "comet tail" behind an LED chaser pattern.
module led_fade_driver #(
  parameter int unsigned N_LEDS     = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DECAY_LOG2 = 14,
  parameter int unsigned DECAY_STEP = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_LEDS-1:0] pattern_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              pwm_sync
);

  localparam int unsigned SUB_W = PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] B_MAX   = '1;
  localparam logic [SUB_W-1:0]    STEP_EXT = SUB_W'(DECAY_STEP);

  logic [N_LEDS-1:0]     pattern_q;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [DECAY_LOG2-1:0] prescaler;
  logic [PWM_BITS-1:0]   bright [N_LEDS];
  logic [PWM_BITS-1:0]   duty   [N_LEDS];

  logic                  decay_tick_c;
  logic                  wrap_c;
  logic [SUB_W-1:0]      diff_c       [N_LEDS];
  logic [PWM_BITS-1:0]   bright_nxt_c [N_LEDS];

  // Period and decay strobes derived from the free-running counters
  always_comb begin
    decay_tick_c = &prescaler;
    wrap_c       = &pwm_cnt;
  end

  // Next brightness: load on pattern, else saturating linear decay on tick
  always_comb begin
    for (int i = 0; i < int'(N_LEDS); i++) begin
      diff_c[i]       = {1'b0, bright[i]} - STEP_EXT;
      bright_nxt_c[i] = bright[i];
      if (pattern_q[i]) begin
        bright_nxt_c[i] = B_MAX;
      end else if (decay_tick_c) begin
        bright_nxt_c[i] = diff_c[i][SUB_W-1] ? '0 : diff_c[i][PWM_BITS-1:0];
      end
    end
  end

  // Input register and free-running PWM / decay counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pattern_q <= '0;
      pwm_cnt   <= '0;
      prescaler <= '0;
    end else begin
      pattern_q <= pattern_in;
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      prescaler <= prescaler + DECAY_LOG2'(1);
    end
  end

  // Brightness state and duty latch; duty only moves at period boundaries
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        bright[i] <= '0;
        duty[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        bright[i] <= bright_nxt_c[i];
        if (wrap_c) begin
          duty[i] <= bright[i];
        end
      end
    end
  end

  // PWM compare; full duty stays high through every slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_out  <= '0;
      pwm_sync <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        led_out[i] <= (duty[i] == B_MAX) || (pwm_cnt < duty[i]);
      end
      pwm_sync <= (pwm_cnt == '0);
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: stimulus pushes the expected output of
// every clock edge, a monitor pops and compares just after each edge.
module tb_led_fade_driver;

  localparam int N     = 8;
  localparam int PBITS = 4;
  localparam int DLOG  = 3;
  localparam int STEP  = 4;
  localparam int PER   = 1 << PBITS;
  localparam int TICK  = 1 << DLOG;
  localparam int MAXB  = PER - 1;

  typedef struct {
    int           n;
    logic [N-1:0] led;
    logic         sync;
  } exp_t;

  logic         clk;
  logic         resetn;
  logic [N-1:0] pattern_in;
  logic [N-1:0] led_out;
  logic         pwm_sync;

  exp_t         sb [$];
  logic [N-1:0] hist [$];
  int           n_edge;
  int           vectors;
  int           miscompares;

  led_fade_driver #(
    .N_LEDS    (N),
    .PWM_BITS  (PBITS),
    .DECAY_LOG2(DLOG),
    .DECAY_STEP(STEP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pattern_in(pattern_in),
    .led_out   (led_out),
    .pwm_sync  (pwm_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Brightness of channel i after edge k: 15 at the last load, minus STEP per
  // decay tick since then, floored at 0. A load at edge m comes from the
  // pattern sampled at edge m-1; decay ticks land on edges that are multiples
  // of TICK. Beyond 40 edges without a load the LED is dark regardless.
  function automatic int bright_after(int k, int i);
    int lo;
    int t;
    int b;
    if (k < 1) return 0;
    lo = (k - 40 > 1) ? k - 40 : 1;
    for (int m = k; m >= lo; m--) begin
      if (hist[m-1][i]) begin
        t = k / TICK - m / TICK;
        b = MAXB - STEP * t;
        return (b < 0) ? 0 : b;
      end
    end
    return 0;
  endfunction

  // Apply a pattern for the coming edge and record the output expected after it
  task automatic drive_edge(input logic [N-1:0] p);
    exp_t e;
    int   slot;
    int   w;
    int   d;
    pattern_in = p;
    n_edge++;
    hist.push_back(p);
    slot = (n_edge - 1) % PER;
    w    = ((n_edge - 1) / PER) * PER;
    e.n  = n_edge;
    for (int i = 0; i < N; i++) begin
      d = (w == 0) ? 0 : bright_after(w - 1, i);
      e.led[i] = (d == MAXB) || (slot < d);
    end
    e.sync = (slot == 0);
    sb.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] p);
    @(negedge clk);
    drive_edge(p);
  endtask

  task automatic hold(input logic [N-1:0] p, input int cycles);
    for (int c = 0; c < cycles; c++) step(p);
  endtask

  // Assert reset away from any clock edge and check outputs clear at once
  task automatic async_reset();
    @(negedge clk);
    pattern_in = '0;
    resetn     = 1'b0;
    #1;
    vectors++;
    if (led_out !== '0 || pwm_sync !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: led_out=%h pwm_sync=%b, required led_out=00 pwm_sync=0",
               led_out, pwm_sync);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (led_out !== '0 || pwm_sync !== 1'b0) begin
      miscompares++;
      $display("FAIL held_reset: led_out=%h pwm_sync=%b, required led_out=00 pwm_sync=0",
               led_out, pwm_sync);
    end
  endtask

  // Release at a falling edge; the next rising edge is edge 1 of the new run
  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    n_edge = 0;
    hist.delete();
    hist.push_back('0);
    drive_edge('0);
  endtask

  // Monitor: compare each edge's outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resetn && sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (led_out !== e.led || pwm_sync !== e.sync) begin
          miscompares++;
          $display("FAIL edge_%0d: led_out=%h pwm_sync=%b, required led_out=%h pwm_sync=%b",
                   e.n, led_out, pwm_sync, e.led, e.sync);
        end
      end
    end
  end

  initial begin
    int           a;
    logic [N-1:0] p;
    vectors     = 0;
    miscompares = 0;
    n_edge      = 0;
    resetn      = 1'b0;
    pattern_in  = '0;
    hist.push_back('0);
    repeat (3) @(negedge clk);
    release_reset();

    // Idle: only pwm_sync pulses
    hold('0, 40);

    // Full-on on channel 0, then reset mid-run while it is lit
    hold(8'h01, 48);
    async_reset();
    release_reset();
    hold('0, 40);

    // Fade profile on channel 3, including saturation at the bottom
    hold(8'h08, 3);
    hold('0, 80);

    // Load-over-decay priority on channel 5: load at 8a+1, bright 7 after
    // two ticks, reload lands exactly on the third tick edge
    while ((n_edge + 1) % TICK != 0) step('0);
    a = (n_edge + 1) / TICK;
    step(8'h20);
    while (n_edge + 1 < TICK * a + TICK * 3 - 1) step('0);
    step(8'h20);
    hold('0, 64);

    // Reset in the middle of a fade discards all brightness
    hold(8'h41, 4);
    hold('0, 12);
    async_reset();
    release_reset();
    hold('0, 36);

    // Chaser sweep: one-hot rotating every TICK cycles
    for (int r = 0; r < 2 * N; r++) begin
      p = '0;
      p[r % N] = 1'b1;
      hold(p, TICK);
    end
    hold('0, 48);

    // Randomised bursts, one-hot and multi-hot
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(1, 0) == 1) begin
        p = '0;
        p[$urandom_range(N - 1, 0)] = 1'b1;
      end else begin
        p = N'($urandom & $urandom);
      end
      hold(p, $urandom_range(12, 1));
      hold('0, $urandom_range(30, 0));
    end
    hold('0, 40);

    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
